// File: rtl/rep_string_sequencer.sv
// Iterates one decoded MOVS (optionally REP-prefixed) into per-iteration issues to execute,
// stepping ESI/EDI and counting ECX down, with flush and interrupt-boundary exit.
module rep_string_sequencer #(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_rep,
    input  logic [1:0]        in_opsize,
    input  logic              in_df,
    input  logic [CNT_W-1:0]  in_ecx,
    input  logic [ADDR_W-1:0] in_esi,
    input  logic [ADDR_W-1:0] in_edi,
    input  logic              int_pending,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [ADDR_W-1:0] iss_esi,
    output logic [ADDR_W-1:0] iss_edi,
    output logic [CNT_W-1:0]  iss_ecx,
    output logic [1:0]        iss_opsize,
    output logic              iss_last,
    output logic              iss_skip,
    output logic              stall_out,
    output logic              resume_valid,
    output logic [CNT_W-1:0]  resume_ecx,
    output logic [ADDR_W-1:0] resume_esi,
    output logic [ADDR_W-1:0] resume_edi
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESUME} state_t;

    state_t            state_reg;
    logic              is_rep_reg;
    logic              df_reg;
    logic [1:0]        opsize_reg;
    logic [CNT_W-1:0]  ecx_reg;
    logic [ADDR_W-1:0] esi_reg;
    logic [ADDR_W-1:0] edi_reg;

    logic [ADDR_W-1:0] step_mag;
    logic [ADDR_W-1:0] step;
    logic              ecx_zero;
    logic [CNT_W-1:0]  ecx_dec;
    logic              cur_last;
    logic              cur_skip;

    // Step magnitude is a one-hot in bits 0..3 selected by opsize (1/2/4/8 bytes).
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_step
            if (gi < 4) begin : g_low
                assign step_mag[gi] = (opsize_reg == 2'(gi));
            end else begin : g_high
                assign step_mag[gi] = 1'b0;
            end
        end
    endgenerate

    assign step     = df_reg ? (~step_mag + ADDR_W'(1)) : step_mag;
    assign ecx_zero = (ecx_reg == '0);
    assign ecx_dec  = ecx_reg - CNT_W'(1);
    assign cur_skip = is_rep_reg & ecx_zero;
    assign cur_last = ~is_rep_reg | ecx_zero | (ecx_reg == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            is_rep_reg <= 1'b0;
            df_reg     <= 1'b0;
            opsize_reg <= 2'd0;
            ecx_reg    <= '0;
            esi_reg    <= '0;
            edi_reg    <= '0;
        end else if (flush) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        is_rep_reg <= in_is_rep;
                        df_reg     <= in_df;
                        opsize_reg <= in_opsize;
                        ecx_reg    <= in_ecx;
                        esi_reg    <= in_esi;
                        edi_reg    <= in_edi;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (iss_ready) begin
                        // A skipped REP (ECX=0) moves nothing, so pointers stay put.
                        if (!cur_skip) begin
                            esi_reg <= esi_reg + step;
                            edi_reg <= edi_reg + step;
                        end
                        if (is_rep_reg && !ecx_zero) begin
                            ecx_reg <= ecx_dec;
                        end
                        if (cur_last) begin
                            state_reg <= IDLE;
                        end else if (int_pending) begin
                            state_reg <= RESUME;
                        end
                    end
                end
                RESUME: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state_reg == IDLE);
    assign stall_out    = (state_reg != IDLE);
    assign iss_valid    = (state_reg == ISSUE);
    assign iss_esi      = esi_reg;
    assign iss_edi      = edi_reg;
    assign iss_ecx      = (is_rep_reg && !ecx_zero) ? ecx_dec : ecx_reg;
    assign iss_opsize   = opsize_reg;
    assign iss_last     = cur_last;
    assign iss_skip     = cur_skip;
    // Registers already hold the post-update values while in RESUME.
    assign resume_valid = (state_reg == RESUME);
    assign resume_ecx   = ecx_reg;
    assign resume_esi   = esi_reg;
    assign resume_edi   = edi_reg;

endmodule

// File: tb/tb_rep_string_sequencer.sv
// Directed bench for rep_string_sequencer: one task per scenario, inline checks.
module tb_rep_string_sequencer;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_is_rep, in_df, int_pending;
    logic [1:0]  in_opsize, iss_opsize;
    logic [31:0] in_ecx, in_esi, in_edi;
    logic        iss_valid, iss_ready, iss_last, iss_skip, stall_out, resume_valid;
    logic [31:0] iss_esi, iss_edi, iss_ecx, resume_ecx, resume_esi, resume_edi;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rep_string_sequencer #(.CNT_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_rep(in_is_rep),
        .in_opsize(in_opsize), .in_df(in_df), .in_ecx(in_ecx),
        .in_esi(in_esi), .in_edi(in_edi), .int_pending(int_pending),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_esi(iss_esi),
        .iss_edi(iss_edi), .iss_ecx(iss_ecx), .iss_opsize(iss_opsize),
        .iss_last(iss_last), .iss_skip(iss_skip), .stall_out(stall_out),
        .resume_valid(resume_valid), .resume_ecx(resume_ecx),
        .resume_esi(resume_esi), .resume_edi(resume_edi)
    );

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a single cycle; returns #1 after that edge.
    task automatic accept(input logic rep, input logic [1:0] opsz, input logic df,
                          input logic [31:0] ecx, input logic [31:0] esi, input logic [31:0] edi);
        in_is_rep = rep; in_opsize = opsz; in_df = df;
        in_ecx = ecx; in_esi = esi; in_edi = edi;
        in_valid = 1'b1;
        step_clk();
        in_valid = 1'b0;
        $display("accept rep=%0b opsize=%0d df=%0b ecx=%0d esi=%h edi=%h", rep, opsz, df, ecx, esi, edi);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step_clk();
        step_clk();
        rst = 1'b0;
        step_clk();
        total++;
        if (in_ready !== 1'b1 || iss_valid !== 1'b0 || stall_out !== 1'b0 || resume_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset: in_ready=%b iss_valid=%b stall=%b resume=%b want 1 0 0 0",
                     in_ready, iss_valid, stall_out, resume_valid);
        end
        $display("reset checked");
    endtask

    task automatic test_nonrep();
        int_pending = 1'b1;  // must be ignored on the last (only) iteration
        in_valid = 1'b1;
        total++;
        if (iss_valid !== 1'b0) begin
            bad++; $display("FAIL nonrep_latency: iss_valid=%b want 0 before accept", iss_valid);
        end
        accept(1'b0, 2'd2, 1'b0, 32'd7, 32'h1000, 32'h2000);
        total++;
        if (iss_valid !== 1'b1 || iss_esi !== 32'h1000 || iss_edi !== 32'h2000 || iss_last !== 1'b1
            || iss_ecx !== 32'd7 || iss_skip !== 1'b0 || iss_opsize !== 2'd2) begin
            bad++;
            $display("FAIL nonrep_issue: v=%b esi=%h edi=%h last=%b ecx=%0d skip=%b op=%0d want 1 1000 2000 1 7 0 2",
                     iss_valid, iss_esi, iss_edi, iss_last, iss_ecx, iss_skip, iss_opsize);
        end
        step_clk();
        total++;
        if (iss_valid !== 1'b0 || in_ready !== 1'b1 || resume_valid !== 1'b0) begin
            bad++;
            $display("FAIL nonrep_done: v=%b in_ready=%b resume=%b want 0 1 0", iss_valid, in_ready, resume_valid);
        end
        int_pending = 1'b0;
        $display("nonrep issue esi=%h edi=%h", 32'h1000, 32'h2000);
    endtask

    task automatic test_rep3();
        logic [31:0] exp_esi, exp_edi;
        accept(1'b1, 2'd1, 1'b1, 32'd3, 32'h100, 32'h200);
        for (int i = 0; i < 3; i++) begin
            exp_esi = 32'h100 - 32'(2 * i);
            exp_edi = 32'h200 - 32'(2 * i);
            total++;
            if (iss_valid !== 1'b1 || stall_out !== 1'b1 || iss_esi !== exp_esi || iss_edi !== exp_edi
                || iss_ecx !== 32'(2 - i) || iss_last !== (i == 2)) begin
                bad++;
                $display("FAIL rep3_iter%0d: v=%b stall=%b esi=%h edi=%h ecx=%0d last=%b want 1 1 %h %h %0d %b",
                         i, iss_valid, stall_out, iss_esi, iss_edi, iss_ecx, iss_last,
                         exp_esi, exp_edi, 2 - i, (i == 2));
            end
            $display("rep3 iter %0d esi=%h ecx=%0d last=%b", i, iss_esi, iss_ecx, iss_last);
            step_clk();
        end
        total++;
        if (stall_out !== 1'b0 || iss_valid !== 1'b0) begin
            bad++; $display("FAIL rep3_end: stall=%b v=%b want 0 0", stall_out, iss_valid);
        end
    endtask

    task automatic test_rep0();
        accept(1'b1, 2'd3, 1'b0, 32'd0, 32'h500, 32'h600);
        total++;
        if (iss_valid !== 1'b1 || iss_skip !== 1'b1 || iss_last !== 1'b1 || iss_esi !== 32'h500
            || iss_edi !== 32'h600 || iss_ecx !== 32'd0) begin
            bad++;
            $display("FAIL rep0_issue: v=%b skip=%b last=%b esi=%h edi=%h ecx=%0d want 1 1 1 500 600 0",
                     iss_valid, iss_skip, iss_last, iss_esi, iss_edi, iss_ecx);
        end
        step_clk();
        total++;
        if (iss_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rep0_done: v=%b in_ready=%b want 0 1", iss_valid, in_ready);
        end
        $display("rep0 skip issue");
    endtask

    task automatic test_hold();
        accept(1'b1, 2'd2, 1'b0, 32'd4, 32'hFFFF_FFF8, 32'h10);
        step_clk();  // first iteration accepted
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (iss_valid !== 1'b1 || iss_esi !== 32'hFFFF_FFFC || iss_edi !== 32'h14 || iss_ecx !== 32'd2
                || iss_last !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d: v=%b esi=%h edi=%h ecx=%0d last=%b want 1 fffffffc 14 2 0",
                         i, iss_valid, iss_esi, iss_edi, iss_ecx, iss_last);
            end
            step_clk();
        end
        iss_ready = 1'b1;
        step_clk();
        total++;
        if (iss_esi !== 32'h0 || iss_edi !== 32'h18 || iss_ecx !== 32'd1) begin
            bad++; $display("FAIL hold_wrap: esi=%h edi=%h ecx=%0d want 0 18 1", iss_esi, iss_edi, iss_ecx);
        end
        step_clk();
        total++;
        if (iss_esi !== 32'h4 || iss_ecx !== 32'd0 || iss_last !== 1'b1) begin
            bad++; $display("FAIL hold_last: esi=%h ecx=%0d last=%b want 4 0 1", iss_esi, iss_ecx, iss_last);
        end
        step_clk();
        $display("hold run finished");
    endtask

    task automatic test_interrupt();
        accept(1'b1, 2'd2, 1'b0, 32'd5, 32'h3000, 32'h4000);
        step_clk();          // first issue accepted, second now presented
        int_pending = 1'b1;
        step_clk();          // second issue accepted with interrupt pending
        int_pending = 1'b0;
        total++;
        if (resume_valid !== 1'b1 || resume_ecx !== 32'd3 || resume_esi !== 32'h3008
            || resume_edi !== 32'h4008 || iss_valid !== 1'b0) begin
            bad++;
            $display("FAIL int_resume: rv=%b ecx=%0d esi=%h edi=%h v=%b want 1 3 3008 4008 0",
                     resume_valid, resume_ecx, resume_esi, resume_edi, iss_valid);
        end
        step_clk();
        total++;
        if (resume_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL int_idle: rv=%b in_ready=%b want 0 1", resume_valid, in_ready);
        end
        $display("interrupt resume ecx=3 esi=3008");
    endtask

    task automatic test_flush();
        accept(1'b1, 2'd0, 1'b0, 32'd5, 32'h700, 32'h800);
        step_clk();
        flush = 1'b1;        // during the 2nd iteration
        step_clk();
        flush = 1'b0;
        total++;
        if (iss_valid !== 1'b0 || in_ready !== 1'b1 || resume_valid !== 1'b0) begin
            bad++; $display("FAIL flush_mid: v=%b in_ready=%b rv=%b want 0 1 0", iss_valid, in_ready, resume_valid);
        end
        flush = 1'b1;        // flush blocks a coincident accept
        accept(1'b0, 2'd0, 1'b0, 32'd1, 32'h900, 32'h901);
        flush = 1'b0;
        total++;
        if (iss_valid !== 1'b0 || stall_out !== 1'b0) begin
            bad++; $display("FAIL flush_accept: v=%b stall=%b want 0 0", iss_valid, stall_out);
        end
        accept(1'b0, 2'd0, 1'b1, 32'd1, 32'hA00, 32'hB00);
        total++;
        if (iss_valid !== 1'b1 || iss_esi !== 32'hA00 || iss_edi !== 32'hB00) begin
            bad++; $display("FAIL flush_recover: v=%b esi=%h edi=%h want 1 a00 b00", iss_valid, iss_esi, iss_edi);
        end
        step_clk();
        $display("flush scenarios done");
    endtask

    task automatic test_rst_mid();
        accept(1'b1, 2'd1, 1'b0, 32'd6, 32'hC00, 32'hD00);
        step_clk();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        total++;
        if (iss_valid !== 1'b0 || stall_out !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid: v=%b stall=%b in_ready=%b want 0 0 1", iss_valid, stall_out, in_ready);
        end
        accept(1'b1, 2'd1, 1'b0, 32'd2, 32'hE00, 32'hF00);
        total++;
        if (iss_valid !== 1'b1 || iss_esi !== 32'hE00 || iss_ecx !== 32'd1 || iss_last !== 1'b0) begin
            bad++; $display("FAIL rst_recover: v=%b esi=%h ecx=%0d last=%b want 1 e00 1 0",
                            iss_valid, iss_esi, iss_ecx, iss_last);
        end
        step_clk();
        total++;
        if (iss_esi !== 32'hE02 || iss_last !== 1'b1) begin
            bad++; $display("FAIL rst_recover2: esi=%h last=%b want e02 1", iss_esi, iss_last);
        end
        step_clk();
        $display("reset mid-run done");
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_is_rep = 1'b0; in_opsize = 2'd0;
        in_df = 1'b0; in_ecx = '0; in_esi = '0; in_edi = '0; int_pending = 1'b0; iss_ready = 1'b1;
        test_reset();
        test_nonrep();
        test_rep3();
        test_rep0();
        test_hold();
        test_interrupt();
        test_flush();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
